pipe_hazard_ctrl: RTL and testbench

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

---
 rtl/pipe_hazard_ctrl.sv | 97 +++++++++
 tb/tb_pipe_hazard_ctrl.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - decode-stage RAW hazard detector with per-register writeback scoreboard
module pipe_hazard_ctrl #(
    parameter int WB_LAT = 3,
    parameter int NREG   = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_valid,
    input  logic [5:0]       id_opcode,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic [4:0]       id_rd,
    input  logic             flush,
    output logic             stall,
    output logic             issue,
    output logic [5:0]       ex_opcode,
    output logic             illegal,
    output logic [NREG-1:0]  busy_vec,
    output logic [15:0]      stall_cnt
);

    localparam logic [2:0] LAT3 = 3'(WB_LAT);

    logic [2:0]      r_cnt [NREG];
    logic [5:0]      r_ex_opcode;
    logic            r_illegal;
    logic [NREG-1:0] r_busy;
    logic [15:0]     r_stall_cnt;

    logic [2:0]      w_cnt_nxt [NREG];
    logic [NREG-1:0] w_busy_nxt;
    logic            w_reads;
    logic            w_writes;
    logic            w_illegal_op;
    logic            w_rs1_busy;
    logic            w_rs2_busy;
    logic            w_go;
    logic            w_hazard;
    logic            w_issue;
    logic            w_load;

    always_comb begin
        w_reads      = (id_opcode >= 6'd1) && (id_opcode <= 6'd20);
        w_writes     = w_reads && (id_opcode != 6'd3);
        w_illegal_op = (id_opcode >= 6'd21);
        w_rs1_busy   = 1'b0;
        w_rs2_busy   = 1'b0;
        // A count of 1 means the write lands this cycle, ahead of the read.
        for (int n = 1; n < NREG; n++) begin
            if ((id_rs1 == 5'(n)) && (r_cnt[n] >= 3'd2)) w_rs1_busy = 1'b1;
            if ((id_rs2 == 5'(n)) && (r_cnt[n] >= 3'd2)) w_rs2_busy = 1'b1;
        end
        w_go     = reset && id_valid && !flush;
        w_hazard = w_go && w_reads && (w_rs1_busy || w_rs2_busy);
        w_issue  = w_go && !w_hazard;
        w_load   = w_issue && w_writes && (id_rd != 5'd0);
    end

    always_comb begin
        w_cnt_nxt[0]  = 3'd0;
        w_busy_nxt    = '0;
        for (int n = 1; n < NREG; n++) begin
            if (w_load && (id_rd == 5'(n)))
                w_cnt_nxt[n] = LAT3;
            else if (r_cnt[n] != 3'd0)
                w_cnt_nxt[n] = r_cnt[n] - 3'd1;
            else
                w_cnt_nxt[n] = 3'd0;
            w_busy_nxt[n] = (w_cnt_nxt[n] >= 3'd2);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int n = 0; n < NREG; n++) r_cnt[n] <= 3'd0;
            r_ex_opcode <= 6'd0;
            r_illegal   <= 1'b0;
            r_busy      <= '0;
            r_stall_cnt <= 16'd0;
        end else begin
            for (int n = 0; n < NREG; n++) r_cnt[n] <= w_cnt_nxt[n];
            r_ex_opcode <= (w_issue && !w_illegal_op) ? id_opcode : 6'd0;
            r_illegal   <= w_issue && w_illegal_op;
            r_busy      <= w_busy_nxt;
            if (w_hazard && (r_stall_cnt != 16'hFFFF))
                r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign stall     = w_hazard;
    assign issue     = w_issue;
    assign ex_opcode = r_ex_opcode;
    assign illegal   = r_illegal;
    assign busy_vec  = r_busy;
    assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - vector table, directed reset sequence and random run against a ready-time model
module tb_pipe_hazard_ctrl;

    localparam int LAT = 3;
    localparam int NR  = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          id_valid;
    logic [5:0]    id_opcode;
    logic [4:0]    id_rs1, id_rs2, id_rd;
    logic          flush;
    logic          stall, issue;
    logic [5:0]    ex_opcode;
    logic          illegal;
    logic [NR-1:0] busy_vec;
    logic [15:0]   stall_cnt;

    pipe_hazard_ctrl #(.WB_LAT(LAT), .NREG(NR)) dut (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_opcode(id_opcode),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .flush(flush),
        .stall(stall), .issue(issue), .ex_opcode(ex_opcode), .illegal(illegal),
        .busy_vec(busy_vec), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: a register is unreadable in cycle c while c < ready[r],
    // where ready[r] = issue cycle + LAT of its latest writer.
    int         ready [NR];
    int         now = 0;
    logic [5:0] m_ex;
    logic       m_ill;
    int         m_scnt;

    function automatic logic m_busy(input int r);
        return (r != 0) && (now < ready[r]);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, now, act, exp);
        end
    endtask

    task automatic step(input logic rst_n, input logic v, input logic [5:0] op,
                        input logic [4:0] a, input logic [4:0] b, input logic [4:0] d,
                        input logic f, output logic s_stall, output logic s_issue);
        logic          go, rd_cls, hz, iss;
        logic [NR-1:0] exp_busy;
        reset = rst_n; id_valid = v; id_opcode = op;
        id_rs1 = a; id_rs2 = b; id_rd = d; flush = f;
        go     = rst_n && v && !f;
        rd_cls = (op >= 1) && (op <= 20);
        hz     = go && rd_cls && (m_busy(int'(a)) || m_busy(int'(b)));
        iss    = go && !hz;
        @(negedge clk);
        s_stall = stall;
        s_issue = issue;
        chk("stall", {31'd0, stall}, {31'd0, hz});
        chk("issue", {31'd0, issue}, {31'd0, iss});
        @(posedge clk);
        if (!rst_n) begin
            for (int i = 0; i < NR; i++) ready[i] = 0;
            m_ex = 6'd0; m_ill = 1'b0; m_scnt = 0;
        end else begin
            if (iss && rd_cls && op != 6'd3 && d != 5'd0) ready[d] = now + LAT;
            m_ex  = (iss && op <= 6'd20) ? op : 6'd0;
            m_ill = iss && (op >= 6'd21);
            if (hz && m_scnt < 65535) m_scnt++;
        end
        now++;
        for (int i = 0; i < NR; i++) exp_busy[i] = m_busy(i);
        #1;
        chk("ex_opcode", {26'd0, ex_opcode}, {26'd0, m_ex});
        chk("illegal",   {31'd0, illegal},   {31'd0, m_ill});
        chk("busy_vec",  busy_vec,           exp_busy);
        chk("stall_cnt", {16'd0, stall_cnt}, m_scnt);
    endtask

    typedef struct {
        logic rst_n, v;
        logic [5:0] op;
        logic [4:0] a, b, d;
        logic f;
        logic e_stall, e_issue;
        logic [5:0] e_ex;
        logic e_ill;
    } vec_t;

    function automatic vec_t mk(input logic rst_n, input logic v, input logic [5:0] op,
                                input logic [4:0] a, input logic [4:0] b, input logic [4:0] d,
                                input logic f, input logic es, input logic ei,
                                input logic [5:0] ex, input logic il);
        vec_t t;
        t.rst_n = rst_n; t.v = v; t.op = op; t.a = a; t.b = b; t.d = d; t.f = f;
        t.e_stall = es; t.e_issue = ei; t.e_ex = ex; t.e_ill = il;
        return t;
    endfunction

    vec_t tbl [20];
    logic s_st, s_is;

    initial begin
        for (int i = 0; i < NR; i++) ready[i] = 0;
        m_ex = 6'd0; m_ill = 1'b0; m_scnt = 0;
        reset = 1'b0; id_valid = 1'b0; id_opcode = 6'd0;
        id_rs1 = 5'd0; id_rs2 = 5'd0; id_rd = 5'd0; flush = 1'b0;

        //            rst v  op  rs1 rs2 rd  fl  stall issue ex  ill
        tbl[0]  = mk(0, 1,  1,  0,  0,  5, 0,  0, 0,  0, 0);
        tbl[1]  = mk(1, 1,  1,  1,  2,  5, 0,  0, 1,  1, 0);
        tbl[2]  = mk(1, 1,  2,  5,  6,  6, 0,  1, 0,  0, 0);
        tbl[3]  = mk(1, 1,  2,  5,  6,  6, 0,  1, 0,  0, 0);
        tbl[4]  = mk(1, 1,  2,  5,  6,  6, 0,  0, 1,  2, 0);
        tbl[5]  = mk(1, 1,  1, 10, 11, 12, 0,  0, 1,  1, 0);
        tbl[6]  = mk(1, 1,  2, 13, 14, 15, 0,  0, 1,  2, 0);
        tbl[7]  = mk(1, 1,  4, 16, 17,  7, 0,  0, 1,  4, 0);
        tbl[8]  = mk(1, 1,  3,  1,  7,  0, 0,  1, 0,  0, 0);
        tbl[9]  = mk(1, 1,  3,  1,  7,  0, 0,  1, 0,  0, 0);
        tbl[10] = mk(1, 1,  3,  1,  7,  0, 0,  0, 1,  3, 0);
        tbl[11] = mk(1, 1,  1,  0,  0,  0, 0,  0, 1,  1, 0);
        tbl[12] = mk(1, 1,  2,  0,  0, 20, 0,  0, 1,  2, 0);
        tbl[13] = mk(1, 1, 40,  0,  0, 21, 0,  0, 1,  0, 1);
        tbl[14] = mk(1, 1,  2, 21,  0, 22, 0,  0, 1,  2, 0);
        tbl[15] = mk(1, 0,  2, 22,  0,  0, 0,  0, 0,  0, 0);
        tbl[16] = mk(1, 1,  1,  1,  2,  9, 0,  0, 1,  1, 0);
        tbl[17] = mk(1, 1,  2,  9,  9,  9, 1,  0, 0,  0, 0);
        tbl[18] = mk(1, 1,  2,  9,  9,  9, 0,  1, 0,  0, 0);
        tbl[19] = mk(1, 1,  2,  9,  9,  9, 0,  0, 1,  2, 0);

        @(posedge clk);
        #1;
        for (int i = 0; i < 20; i++) begin
            step(tbl[i].rst_n, tbl[i].v, tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].d, tbl[i].f, s_st, s_is);
            chk("tbl_stall", {31'd0, s_st},   {31'd0, tbl[i].e_stall});
            chk("tbl_issue", {31'd0, s_is},   {31'd0, tbl[i].e_issue});
            chk("tbl_ex",    {26'd0, ex_opcode}, {26'd0, tbl[i].e_ex});
            chk("tbl_ill",   {31'd0, illegal}, {31'd0, tbl[i].e_ill});
        end
        // Stalls: LAT-1 each for rd=5, rd=7 and rd=9 (flushed cycle does not count).
        chk("tbl_stall_total", {16'd0, stall_cnt}, 3 * (LAT - 1) - 1);

        // Reset with a write pending on r5 discards it.
        step(1, 1, 6'd1, 5'd0, 5'd0, 5'd5, 0, s_st, s_is);
        chk("rst_busy5_before", {31'd0, busy_vec[5]}, 32'd1);
        step(0, 1, 6'd2, 5'd5, 5'd0, 5'd6, 0, s_st, s_is);
        chk("rst_stall", {31'd0, s_st}, 32'd0);
        chk("rst_issue", {31'd0, s_is}, 32'd0);
        chk("rst_busy", busy_vec, 32'd0);
        chk("rst_scnt", {16'd0, stall_cnt}, 32'd0);
        chk("rst_ex", {26'd0, ex_opcode}, 32'd0);
        step(1, 1, 6'd2, 5'd5, 5'd0, 5'd6, 0, s_st, s_is);
        chk("post_rst_issue", {31'd0, s_is}, 32'd1);
        chk("post_rst_stall", {31'd0, s_st}, 32'd0);

        for (int i = 0; i < 3000; i++) begin
            logic       r_n, v, f;
            logic [5:0] op;
            int         sel;
            r_n = ($urandom_range(0, 49) != 0);
            v   = ($urandom_range(0, 4) != 0);
            f   = ($urandom_range(0, 9) == 0);
            sel = $urandom_range(0, 9);
            if (sel == 0)      op = 6'd0;
            else if (sel == 1) op = 6'd3;
            else if (sel == 2) op = 6'($urandom_range(21, 63));
            else               op = 6'($urandom_range(1, 20));
            step(r_n, v, op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                 5'($urandom_range(0, 7)), f, s_st, s_is);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
